blink_multi: RTL and testbench
==============================

# blink_multi

Multi-channel, parametrised LED sequencer and the successor to the single-LED blinker. It drives `CHANNELS` independent outputs, each configured at run time through a valid/ready write port to OFF, ON, continuous BLINK, or counted BURST. All timing derives from one shared prescaler tick, so periods and on-times are set in ticks rather than clock cycles. The block sits between the board clock/reset and the LED pins, and is written to by a control FSM or CSR bridge.

## Interface
- `CLK_HZ`, 100000000: input clock frequency.
- `TICK_HZ`, 1000: prescaler tick rate. `TICK_DIV = CLK_HZ/TICK_HZ` must be ≥2; elaboration fails otherwise.
- `CHANNELS`, 4: number of LED channels, ≥1.
- `PERIOD_W`, 16: width of the period and on-time fields, in ticks.
- `CNT_W`, 8: width of the burst count.
- `clk_i`, in, 1: single clock.
- `arst_n_i`, in, 1: reset, asynchronous, active-low.
- `cfg_valid_i`, in, 1: configuration write request.
- `cfg_ready_o`, out, 1: write can be accepted.
- `cfg_chan_i`, in, `max(1,$clog2(CHANNELS))`: target channel. Values ≥`CHANNELS` are accepted and ignored.
- `cfg_mode_i`, in, 2: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
- `cfg_period_i`, in, `PERIOD_W`: period in ticks.
- `cfg_on_i`, in, `PERIOD_W`: on-phase length in ticks.
- `cfg_count_i`, in, `CNT_W`: number of BURST pulses.
- `led_o`, out, `CHANNELS`: LED drive, registered.
- `busy_o`, out, `CHANNELS`: channel is in BLINK or BURST.
- `done_o`, out, `CHANNELS`: one-cycle pulse when a BURST completes.

## Operation
- The write is accepted on `cfg_valid_i & cfg_ready_o`. The addressed channel loads mode/period/on/count and restarts with phase counter 0.
- Prescaler is free-running, counts 0..`TICK_DIV-1`, and raises `tick` for one cycle at the wrap. A config write does not reset it.
- Per-channel state is `{mode, period, on, remaining, phase}`.
- **OFF:** `led_o`=0 and `busy_o`=0.
- **ON:** `led_o`=1 and `busy_o`=0.
- **BLINK:**
  - `led_o` = (`phase < on`).
  - On each tick, `phase` increments and wraps from `period-1` to 0.
  - `on` ≥ `period` gives constant high. `on`=0 gives constant low while `busy_o` stays 1.
- **BURST:**
  - Behaves as BLINK, and `remaining` is decremented at each phase wrap.
  - When `remaining` reaches 0 at a wrap: mode→OFF, `led_o`=0, `busy_o`=0, and `done_o` pulses.
  - `cfg_count_i`=0: channel goes OFF and `done_o` pulses on the cycle after acceptance.
- `period`=0 in BLINK/BURST: treated as OFF, with no `done_o`.
- A write to a busy channel aborts the current operation immediately. No `done_o` is issued for the aborted burst.
- Write and tick in the same cycle: the write wins, `phase`=0, and that tick is not applied to that channel.
- Channels are fully independent. A write affects only the addressed channel.

## Timing
- Reset values: `led_o`=0, `busy_o`=0, `done_o`=0, `cfg_ready_o`=0, all modes OFF, prescaler 0.
- `cfg_ready_o` rises on the first clock edge after `arst_n_i` deasserts and stays 1 until the next reset.
- Write accepted at edge k: `led_o`/`busy_o` reflect the new mode after edge k+1 (one-cycle latency).
- First BLINK/BURST phase is 0..1 tick shorter than programmed because the prescaler is unaligned. All later phases are exact.
- `done_o` is asserted in the same cycle that `busy_o` falls.
- Reset asserted mid-operation: all outputs clear asynchronously. Configuration is lost.

## Configuration
- `BLINK_PWM_EN` defined:
  - Adds input `cfg_level_i[7:0]`, stored per channel.
  - A free-running 8-bit clock-rate counter gates the on-phase: `led_o` = on-phase & (`pwm_cnt < level`).
  - Level 0 gives dark. Level 255 gives a 255/256 duty cycle.
  - Applies to ON, BLINK and BURST.
- `BLINK_PWM_EN` undefined: the port is absent and the on-phase is solid high.

## Structure
- `blink_pkg`:
  - mode enum `blink_mode_e` {`BLINK_OFF`, `BLINK_ON`, `BLINK_BLINK`, `BLINK_BURST`}.
  - `PWM_W`=8.
  - Per-channel config struct.
- Sub-module `blink_chan` holds one channel's state machine, counters and output register. The top contains the prescaler, the optional PWM counter and the write decode, plus a generate loop over `blink_chan`.

## Test plan
All scenarios use `CLK_HZ`=100 and `TICK_HZ`=10, giving one tick every 10 cycles.
- Hold `arst_n_i` low, then release. All outputs are 0 during reset; `cfg_ready_o`=1 one cycle after release; `led_o`=0.
- Ch0 BLINK, period 4, on 1: steady-state `led_o[0]` is high 10 cycles out of every 40; `busy_o[0]`=1; other channels stay 0.
- Ch1 BURST, period 2, on 1, count 3: three high pulses, then `done_o[1]` pulses once, `busy_o[1]` falls on the same cycle, and `led_o[1]`=0 afterwards.
- Ch2 BURST, count 0: `done_o[2]` pulses on the cycle after acceptance and `led_o[2]` stays 0.
- Abort BURST on ch1 mid-run with an ON write: `led_o[1]`=1 one cycle later and `done_o[1]` never pulses. Separately, a write coinciding with a tick leaves `phase`=0.
- With `BLINK_PWM_EN`, ON with level 64: `led_o` is high for 64 of every 256 cycles. Assert reset mid-run: all outputs drop to 0 immediately.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types for the multi-channel LED sequencer: channel modes, the
// per-channel configuration record and the PWM counter width.
package blink_pkg;

    localparam int unsigned PWM_W = 8;

    typedef enum logic [1:0] {
        BLINK_OFF   = 2'd0,
        BLINK_ON    = 2'd1,
        BLINK_BLINK = 2'd2,
        BLINK_BURST = 2'd3
    } blink_mode_e;

    typedef struct packed {
        blink_mode_e       mode;
        logic [PWM_W-1:0]  level;
    } blink_cfg_t;

    function automatic logic mode_busy(blink_mode_e m);
        return (m == BLINK_BLINK) || (m == BLINK_BURST);
    endfunction

endpackage

// File: rtl/blink_chan.sv
// One LED channel: mode state machine, phase/burst counters and the
// registered led/busy/done outputs.
module blink_chan
    import blink_pkg::*;
#(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                wr,
    input  blink_cfg_t          cfg,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] on_time,
    input  logic [CNT_W-1:0]    count,
    input  logic                tick,
    input  logic [PWM_W-1:0]    pwm_cnt,
    output logic                led,
    output logic                busy,
    output logic                done
);

    blink_mode_e         mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] on_q, on_d;
    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [PWM_W-1:0]    level_q, level_d;
    logic                done_evt_q, done_evt_d;
    logic                led_d, busy_d, gate;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mode_q      <= BLINK_OFF;
            period_q    <= '0;
            on_q        <= '0;
            phase_q     <= '0;
            remaining_q <= '0;
            level_q     <= '0;
            done_evt_q  <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            period_q    <= period_d;
            on_q        <= on_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            level_q     <= level_d;
            done_evt_q  <= done_evt_d;
        end
    end

    // A write overrides any tick in the same cycle, so the new config starts at phase 0.
    always_comb begin
        mode_d      = mode_q;
        period_d    = period_q;
        on_d        = on_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        level_d     = level_q;
        done_evt_d  = 1'b0;
        if (wr) begin
            mode_d      = cfg.mode;
            period_d    = period;
            on_d        = on_time;
            phase_d     = '0;
            remaining_d = count;
            level_d     = cfg.level;
            if (mode_busy(cfg.mode) && (period == '0)) begin
                mode_d = BLINK_OFF;
            end else if ((cfg.mode == BLINK_BURST) && (count == '0)) begin
                mode_d     = BLINK_OFF;
                done_evt_d = 1'b1;
            end
        end else if (tick && mode_busy(mode_q)) begin
            if (phase_q >= period_q - 1'b1) begin
                phase_d = '0;
                if (mode_q == BLINK_BURST) begin
                    if (remaining_q <= CNT_W'(1)) begin
                        mode_d     = BLINK_OFF;
                        done_evt_d = 1'b1;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_comb begin
        gate   = (pwm_cnt < level_q);
        led_d  = 1'b0;
        busy_d = 1'b0;
        case (mode_q)
            BLINK_ON: led_d = gate;
            BLINK_BLINK, BLINK_BURST: begin
                led_d  = (phase_q < on_q) && gate;
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    // done is delayed alongside busy so it pulses in the cycle busy falls.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            led  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            led  <= led_d;
            busy <= busy_d;
            done <= done_evt_q;
        end
    end

endmodule

// File: rtl/blink_multi.sv
// Multi-channel LED sequencer top: shared prescaler, write decode and channel array.
// Optional per-channel PWM dimming is enabled by defining BLINK_PWM_EN.
module blink_multi
    import blink_pkg::*;
#(
    parameter  int unsigned CLK_HZ   = 100000000,
    parameter  int unsigned TICK_HZ  = 1000,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned PERIOD_W = 16,
    parameter  int unsigned CNT_W    = 8,
    localparam int unsigned CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CHAN_W-1:0]   cfg_chan_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    input  logic [PERIOD_W-1:0] cfg_on_i,
    input  logic [CNT_W-1:0]    cfg_count_i,
`ifdef BLINK_PWM_EN
    input  logic [PWM_W-1:0]    cfg_level_i,
`endif
    output logic [CHANNELS-1:0] led_o,
    output logic [CHANNELS-1:0] busy_o,
    output logic [CHANNELS-1:0] done_o
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (TICK_DIV < 2) begin : g_bad_div
        $error("blink_multi: CLK_HZ/TICK_HZ must be at least 2");
    end

    logic [PRE_W-1:0] presc;
    logic             tick;
    logic             accept;
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] level;
    blink_cfg_t       wr_cfg;

    assign tick   = (presc == PRE_W'(TICK_DIV - 1));
    assign accept = cfg_valid_i && cfg_ready_o;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            presc       <= '0;
            cfg_ready_o <= 1'b0;
        end else begin
            presc       <= tick ? '0 : presc + 1'b1;
            cfg_ready_o <= 1'b1;
        end
    end

`ifdef BLINK_PWM_EN
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) pwm_cnt <= '0;
        else           pwm_cnt <= pwm_cnt + 1'b1;
    end
    assign level = cfg_level_i;
`else
    // Counter at 0 against a full-scale level keeps the on-phase solid.
    assign pwm_cnt = '0;
    assign level   = '1;
`endif

    always_comb begin
        wr_cfg.mode  = blink_mode_e'(cfg_mode_i);
        wr_cfg.level = level;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        blink_chan #(
            .PERIOD_W(PERIOD_W),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk    (clk_i),
            .arst_n (arst_n_i),
            .wr     (accept && (cfg_chan_i == CHAN_W'(g))),
            .cfg    (wr_cfg),
            .period (cfg_period_i),
            .on_time(cfg_on_i),
            .count  (cfg_count_i),
            .tick   (tick),
            .pwm_cnt(pwm_cnt),
            .led    (led_o[g]),
            .busy   (busy_o[g]),
            .done   (done_o[g])
        );
    end

endmodule

// File: tb/tb_blink_multi.sv
// Directed bench for blink_multi at CLK_HZ=100, TICK_HZ=10 (one tick per 10 cycles).
// Also exercises the PWM level path when built with BLINK_PWM_EN.
module tb_blink_multi;

`ifdef BLINK_PWM_EN
    localparam int LVL = 255;
`else
    localparam int LVL = 256;
`endif

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_chan = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_period = '0;
    logic [15:0] cfg_on = '0;
    logic [7:0]  cfg_count = '0;
`ifdef BLINK_PWM_EN
    logic [7:0]  cfg_level = '1;
`endif
    logic [3:0]  led, busy, done;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Edges since reset release; equals the prescaler phase modulo 10.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    blink_multi #(
        .CLK_HZ  (100),
        .TICK_HZ (10),
        .CHANNELS(4),
        .PERIOD_W(16),
        .CNT_W   (8)
    ) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_chan_i  (cfg_chan),
        .cfg_mode_i  (cfg_mode),
        .cfg_period_i(cfg_period),
        .cfg_on_i    (cfg_on),
        .cfg_count_i (cfg_count),
`ifdef BLINK_PWM_EN
        .cfg_level_i (cfg_level),
`endif
        .led_o       (led),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected PWM gate for the led value visible after edge c.
    function automatic int gate(input int c, input int lvl);
        return ((((c - 1) & 255) < lvl) ? 1 : 0);
    endfunction

    task automatic write_cfg(input int ch, input int mode, input int per,
                             input int on_t, input int cnt, input int lvl);
        cfg_chan   = 2'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = 16'(per);
        cfg_on     = 16'(on_t);
        cfg_count  = 8'(cnt);
`ifdef BLINK_PWM_EN
        cfg_level  = 8'(lvl);
`else
        if (lvl < 0) cfg_count = '0;
`endif
        cfg_valid  = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid  = 1'b0;
    endtask

    // Leaves the bench just after an edge where the next edge carries a tick.
    task automatic align_tick;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (cyc % 10 == 9) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int hi, ehi, hi2, ehi2, bz, oth, dn, didx, b, l, prev, eprev, rises, erises;
        int bd, bb, bprev, last;

        // Reset
        repeat (3) @(negedge clk);
        check_eq("rst_led", int'(led), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_ready", int'(cfg_ready), 0);
        arst_n = 1'b1;
        #1;
        check_eq("ready_before_edge", int'(cfg_ready), 0);
        @(negedge clk);
        check_eq("ready_after_edge", int'(cfg_ready), 1);
        check_eq("led_after_rst", int'(led), 0);

        // BLINK ch0, period 4, on 1, write coincides with a tick
        align_tick();
        write_cfg(0, 2, 4, 1, 0, LVL);
        hi = 0; ehi = 0; hi2 = 0; ehi2 = 0; bz = 0; oth = 0;
        for (int s = 0; s < 52; s++) begin
            @(negedge clk);
            b = (s >= 1 && ((s - 1) % 40) < 10) ? gate(cyc, LVL) : 0;
            if (s < 12) begin hi += int'(led[0]); ehi += b; end
            else begin hi2 += int'(led[0]); ehi2 += b; end
            if (s >= 1) bz += int'(busy[0]);
            oth += int'(|led[3:1]) + int'(|busy[3:1]);
        end
        check_eq("blink_first_phase", hi, ehi);
        check_eq("blink_steady_40", hi2, ehi2);
        check_eq("blink_busy", bz, 51);
        check_eq("blink_others_idle", oth, 0);

        // BURST ch1, period 2, on 1, count 3
        align_tick();
        write_cfg(1, 3, 2, 1, 3, LVL);
        hi = 0; ehi = 0; prev = 0; eprev = 0; rises = 0; erises = 0;
        dn = 0; didx = -1; bd = -1; bb = -1; bprev = 0; last = -1;
        for (int s = 0; s < 80; s++) begin
            @(negedge clk);
            b = (s >= 1 && s <= 60 && ((s - 1) % 20) < 10) ? gate(cyc, LVL) : 0;
            l = int'(led[1]);
            hi += l; ehi += b;
            if (l == 1 && prev == 0) rises++;
            if (b == 1 && eprev == 0) erises++;
            prev = l; eprev = b;
            if (done[1]) begin
                dn++;
                if (didx < 0) begin didx = s; bd = int'(busy[1]); bb = bprev; end
            end
            bprev = int'(busy[1]);
            last = l;
        end
        check_eq("burst_high_cycles", hi, ehi);
        check_eq("burst_pulses", rises, erises);
        check_eq("burst_done_count", dn, 1);
        check_eq("burst_done_cycle", didx, 61);
        check_eq("burst_busy_at_done", bd, 0);
        check_eq("burst_busy_before_done", bb, 1);
        check_eq("burst_led_after", last, 0);

        // BURST ch2 with count 0
        write_cfg(2, 3, 5, 2, 0, LVL);
        hi = 0; bz = 0; dn = 0; didx = -1;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            hi += int'(led[2]); bz += int'(busy[2]);
            if (done[2]) begin dn++; if (didx < 0) didx = s; end
        end
        check_eq("cnt0_done_cycle", didx, 1);
        check_eq("cnt0_done_count", dn, 1);
        check_eq("cnt0_led", hi, 0);
        check_eq("cnt0_busy", bz, 0);

        // BLINK ch3 with period 0 behaves as OFF
        write_cfg(3, 2, 0, 3, 0, LVL);
        hi = 0; bz = 0; dn = 0;
        for (int s = 0; s < 30; s++) begin
            @(negedge clk);
            hi += int'(led[3]); bz += int'(busy[3]); dn += int'(done[3]);
        end
        check_eq("per0_led", hi, 0);
        check_eq("per0_busy", bz, 0);
        check_eq("per0_done", dn, 0);

        // Abort a 5-pulse BURST on ch1 with an ON write during its low phase
        align_tick();
        write_cfg(1, 3, 2, 1, 5, LVL);
        repeat (14) begin @(posedge clk); #1; end
        write_cfg(1, 1, 0, 0, 0, LVL);
        hi = 0; ehi = 0; bz = 0; dn = 0; bd = -1; bb = -1;
        for (int s = 0; s < 250; s++) begin
            @(negedge clk);
            if (s == 0) bb = int'(led[1]);
            if (s == 1) begin bd = int'(led[1]); ehi2 = gate(cyc, LVL); end
            if (s >= 1) begin hi += int'(led[1]); ehi += gate(cyc, LVL); bz += int'(busy[1]); end
            dn += int'(done[1]);
        end
        check_eq("abort_led_latency0", bb, 0);
        check_eq("abort_led_latency1", bd, ehi2);
        check_eq("abort_on_high", hi, ehi);
        check_eq("abort_busy", bz, 0);
        check_eq("abort_no_done", dn, 0);

        // OFF write to the blinking ch0
        write_cfg(0, 0, 0, 0, 0, LVL);
        @(negedge clk);
        check_eq("off_busy_latency0", int'(busy[0]), 1);
        @(negedge clk);
        check_eq("off_busy", int'(busy[0]), 0);
        check_eq("off_led", int'(led[0]), 0);

`ifdef BLINK_PWM_EN
        // ON with level 64 on ch3
        write_cfg(3, 1, 0, 0, 0, 64);
        hi = 0; ehi = 0;
        for (int s = 0; s < 257; s++) begin
            @(negedge clk);
            if (s >= 1) begin hi += int'(led[3]); ehi += gate(cyc, 64); end
        end
        check_eq("pwm_level64", hi, ehi);
        check_eq("pwm_level64_abs", hi, 64);
`endif

        // Reset mid-run with ch1 ON and ch2 blinking
        write_cfg(2, 2, 4, 2, 0, LVL);
        repeat (3) @(negedge clk);
        check_eq("pre_rst_busy2", int'(busy[2]), 1);
        check_eq("pre_rst_led1", int'(led[1]), gate(cyc, LVL));
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        check_eq("midrst_led", int'(led), 0);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_done", int'(done), 0);
        check_eq("midrst_ready", int'(cfg_ready), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
